// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the two-requester memory
// arbiter (mem_arb_m) and its round-robin picker (rr_pick2_m).
//   arb_state_e     : arbiter FSM state encoding
//   MEM_ARB_AW/DW   : default memory address / data widths
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2,
        ARB_ACK  = 2'd3
    } arb_state_e;

    localparam int MEM_ARB_AW = 5;
    localparam int MEM_ARB_DW = 8;

endpackage

// File: rtl/mem_arb_m_rr_pick2.sv
// rr_pick2_m: combinational two-way round-robin picker.
// Ports:
//   req_i   [1:0] request vector (bit N = requester N)
//   last_i        requester granted most recently
//   grant_o [1:0] one-hot grant, all zero when nothing is requested
//   owner_o       index of the granted requester (0 when nothing requested)
module rr_pick2_m (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o,
    output logic       owner_o
);

    always_comb begin
        grant_o = 2'b00;
        owner_o = 1'b0;
        case (req_i)
            2'b01: begin
                grant_o = 2'b01;
                owner_o = 1'b0;
            end
            2'b10: begin
                grant_o = 2'b10;
                owner_o = 1'b1;
            end
            2'b11: begin
                // Tie: the requester that did not win last time goes next.
                owner_o = ~last_i;
                grant_o = last_i ? 2'b01 : 2'b10;
            end
            default: begin
                grant_o = 2'b00;
                owner_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arb_m.sv
// mem_arb_m: arbitrates a single-port memory between requester 0 (CPU) and
// requester 1 (loader/DMA). Each transfer takes three cycles:
// grant (IDLE) -> access (RD or WR) -> ACK strobe.
// Handshake: a requester raises reqN with wrN/addrN/wdataN stable and holds
// them until ackN is high; it drops reqN on the clock edge that ends ackN.
// Operands are latched at grant, so dropping req early still completes.
// Ports:
//   clk, rst_            clock, asynchronous active-low reset
//   req/wr/addr/wdataN   per-requester transfer request and operands
//   ack0, ack1           one-cycle completion strobes
//   rdata                registered read data (valid with ack after a read)
//   busy                 high whenever the arbiter is not idle
//   mem_addr/mem_wdata   shared memory address/data (zero when not accessing)
//   mem_rd, mem_wr       memory read enable (async) / write enable (posedge)
//   mem_rdata            memory read data
//   dbg_state_o          current FSM state, for observation
module mem_arb_m
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_ARB_AW,
    parameter int DW = MEM_ARB_DW
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state_o
);

    arb_state_e    state_q;
    logic          owner_q;
    logic          last_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    logic [1:0]    grant;
    logic          pick_owner;

    rr_pick2_m u_pick (
        .req_i   ({req1, req0}),
        .last_i  (last_q),
        .grant_o (grant),
        .owner_o (pick_owner)
    );

    // last_q resets to 1 so the first tie after reset goes to requester 0.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|grant) begin
                        owner_q <= pick_owner;
                        last_q  <= pick_owner;
                        wr_q    <= pick_owner ? wr1 : wr0;
                        addr_q  <= pick_owner ? addr1 : addr0;
                        wdata_q <= pick_owner ? wdata1 : wdata0;
                        state_q <= (pick_owner ? wr1 : wr0) ? ARB_WR : ARB_RD;
                    end
                end
                ARB_RD: begin
                    rdata_q <= mem_rdata;
                    state_q <= ARB_ACK;
                end
                ARB_WR:  state_q <= ARB_ACK;
                ARB_ACK: state_q <= ARB_IDLE;
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Memory strobes are decoded straight from the state so an asynchronous
    // reset removes mem_wr before the next edge.
    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != ARB_IDLE);
        unique case (state_q)
            ARB_IDLE: ;
            ARB_RD: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q;
            end
            ARB_WR: begin
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            ARB_ACK: begin
                ack0 = ~owner_q;
                ack1 = owner_q;
            end
        endcase
    end

    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arb_m.sv
module tb_mem_arb_m;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       wr0 = 1'b0, wr1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, mem_rd, mem_wr;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // clock
    always #5 clk = ~clk;

    mem_arb_m #(.AW(5), .DW(8)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .req0        (req0),
        .req1        (req1),
        .wr0         (wr0),
        .wr1         (wr1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata       (rdata),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_rdata   (mem_rdata),
        .dbg_state_o (dbg_state)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 10) return 8'h3C;
        if (i == 3) return 8'h11;
        return 8'(i * 5 + 7);
    endfunction

    // memory environment: async read, posedge write
    logic [7:0] mem [0:31];
    logic       mem_loaded = 1'b0;
    assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: m_step counts the cycles left in the current
    // transfer (2 = access cycle next, 1 = ack cycle next, 0 = free).
    int         m_step = 0;
    logic       m_last = 1'b1;
    logic       m_owner = 1'b0;
    logic       m_wr = 1'b0;
    logic [4:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] m_rdata = '0;
    logic [7:0] ref_mem [0:31];
    logic       ref_loaded = 1'b0;

    always @(posedge clk or negedge rst_) begin
        if (!ref_loaded) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
            ref_loaded = 1'b1;
        end
        if (!rst_) begin
            m_step = 0;
            m_last = 1'b1;
            m_rdata = '0;
        end else if (m_step == 0) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? !m_last : req1;
                m_last  = m_owner;
                m_wr    = m_owner ? wr1 : wr0;
                m_addr  = m_owner ? addr1 : addr0;
                m_wdata = m_owner ? wdata1 : wdata0;
                m_step  = 2;
            end
        end else if (m_step == 2) begin
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else m_rdata = ref_mem[m_addr];
            m_step = 1;
        end else begin
            m_step = 0;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        chk("ack0", ack0, (m_step == 1) && !m_owner);
        chk("ack1", ack1, (m_step == 1) && m_owner);
        chk("busy", busy, m_step != 0);
        chk("mem_rd", mem_rd, (m_step == 2) && !m_wr);
        chk("mem_wr", mem_wr, (m_step == 2) && m_wr);
        chk("mem_addr", mem_addr, (m_step == 2) ? m_addr : 5'd0);
        chk("mem_wdata", mem_wdata, ((m_step == 2) && m_wr) ? m_wdata : 8'd0);
        chk("rdata", rdata, m_rdata);
    end

    // grant-order scoreboard: expected owner of each ack, in order
    logic [0:0] exp_q[$];
    always @(negedge clk) begin
        if ((ack0 || ack1) && exp_q.size() > 0) begin
            chk("grant_order", ack1, exp_q.pop_front());
        end
    end

    // driver: one transfer; returns negedges until ack (3 from idle) and rdata
    task automatic do_req(input int who, input logic w, input logic [4:0] a,
                          input logic [7:0] d, input bit keep,
                          output int lat, output logic [7:0] rd);
        lat = 0;
        rd  = '0;
        if (who == 0) begin
            wr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        end else begin
            wr1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((who == 0 && ack0) || (who == 1 && ack1)) begin
                lat = n;
                rd  = rdata;
                break;
            end
        end
        chk("ack_seen", lat != 0, 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            if (who == 0) req0 = 1'b0;
            else req1 = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         lat, lat_b;
    logic [7:0] rd, rd_b;
    int         ack_cnt, busy_cnt, diff_cnt;

    initial begin
        // reset
        repeat (3) tick();
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_state", dbg_state, ARB_IDLE);
        rst_ = 1'b1;
        tick();

        // read of a preloaded location by requester 0
        do_req(0, 1'b0, 5'h0A, 8'h00, 1'b0, lat, rd);
        chk("rd_latency", lat, 3);
        chk("rd_data", rd, 8'h3C);

        // write by requester 1 then read it back by requester 0
        do_req(1, 1'b1, 5'h1F, 8'hA5, 1'b0, lat, rd);
        chk("wr_latency", lat, 3);
        tick();
        chk("wr_mem", mem[31], 8'hA5);
        chk("wr_keeps_rdata", rdata, 8'h3C);
        do_req(0, 1'b0, 5'h1F, 8'h00, 1'b0, lat, rd);
        chk("readback", rd, 8'hA5);

        // req0 dropped the cycle after its grant
        addr0 = 5'h0A; wr0 = 1'b0; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        ack_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack0) ack_cnt++;
            if (busy) busy_cnt++;
        end
        chk("early_drop_acks", ack_cnt, 1);
        chk("early_drop_busy", busy_cnt, 2);
        tick();

        // reset during a write access
        addr1 = 5'h03; wdata1 = 8'hFF; wr1 = 1'b1; req1 = 1'b1;
        tick();
        chk("pre_reset_mem_wr", mem_wr, 1'b1);
        rst_ = 1'b0;
        #1;
        chk("reset_drops_mem_wr", mem_wr, 1'b0);
        chk("reset_busy_low", busy, 1'b0);
        chk("reset_state_idle", dbg_state, ARB_IDLE);
        chk("reset_rdata_zero", rdata, 8'h00);
        req1 = 1'b0;
        wr1 = 1'b0;
        repeat (2) tick();
        rst_ = 1'b1;
        repeat (2) tick();
        chk("no_write_mem3", mem[3], 8'h11);

        // continuous dual requests after reset: first tie to 0, then alternate
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        fork
            begin
                do_req(0, 1'b0, 5'h0A, 8'h00, 1'b1, lat, rd);
                chk("dual_first_lat", lat, 3);
                chk("dual_first_rd", rd, 8'h3C);
                do_req(0, 1'b0, 5'h04, 8'h00, 1'b0, lat, rd);
                chk("dual_rd_after_wr", rd, 8'h44);
            end
            begin
                do_req(1, 1'b1, 5'h04, 8'h44, 1'b1, lat_b, rd_b);
                do_req(1, 1'b1, 5'h05, 8'h55, 1'b0, lat_b, rd_b);
            end
        join
        repeat (3) tick();
        chk("grant_q_empty", exp_q.size(), 0);

        diff_cnt = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) diff_cnt++;
        chk("mem_contents", diff_cnt, 0);
        chk("mem5", mem[5], 8'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arb_m.md
MEM_ARB_M -- requirements
Module: mem_arb_m

Interface
REQ-001 SHALL have parameter AW, default 5, memory address width.
REQ-002 SHALL have parameter DW, default 8, memory data width.
REQ-003 Port clk  input  1  system clock; all state updates on posedge.
REQ-004 Port rst_  input  1  reset, asynchronous, active-low.
REQ-005 Ports req0/req1  input  1  transfer request from requester 0 (CPU) / 1 (loader/DMA).
REQ-006 Ports wr0/wr1  input  1  1 = write, 0 = read, per requester.
REQ-007 Ports addr0/addr1  input  AW  transfer address, per requester.
REQ-008 Ports wdata0/wdata1  input  DW  write data, per requester.
REQ-009 Ports ack0/ack1  output  1  one-cycle transfer-complete strobe, per requester.
REQ-010 Port rdata  output  DW  registered read data, valid while ack0 or ack1 is high after a read.
REQ-011 Port busy  output  1  high in every state except ARB_IDLE.
REQ-012 Ports mem_addr  output  AW, mem_wdata  output  DW  shared memory address/data.
REQ-013 Ports mem_rd  output  1 (asynchronous read enable), mem_wr  output  1 (synchronous posedge write enable).
REQ-014 Port mem_rdata  input  DW  memory read data, valid combinationally while mem_rd is high.

Function
REQ-015 SHALL implement states ARB_IDLE, ARB_RD, ARB_WR, ARB_ACK.
REQ-016 In ARB_IDLE with no request: remain in ARB_IDLE; all strobes low.
REQ-017 In ARB_IDLE with exactly one reqN high: grant N; latch addrN, wdataN, wrN, owner=N; go to ARB_WR if wrN else ARB_RD.
REQ-018 Both requests high in ARB_IDLE: grant the requester that is not last_owner (round-robin); last_owner updated at grant.
REQ-019 ARB_RD (one cycle): mem_rd=1, mem_addr=latched addr; rdata captures mem_rdata at cycle-ending posedge; go to ARB_ACK.
REQ-020 ARB_WR (one cycle): mem_wr=1, mem_addr/mem_wdata=latched values; write occurs at cycle-ending posedge; go to ARB_ACK.
REQ-021 ARB_ACK (one cycle): ack of owner =1, other ack =0; rdata holds value; go to ARB_IDLE unconditionally.
REQ-022 Latency: request sampled at posedge N -> access cycle N..N+1 -> ack high cycle N+1..N+2; one transfer per 3 cycles.
REQ-023 Requests arriving outside ARB_IDLE SHALL wait; not dropped, not queued beyond the level req.
REQ-024 Requester SHALL hold req and operands until ack; requester SHALL drop req on ack edge, else it is a new request.
REQ-025 Req deasserted after grant: transfer still completes and ack still issues (operands are latched).
REQ-026 mem_rd and mem_wr SHALL never be high together; neither high outside ARB_RD/ARB_WR.
REQ-027 mem_addr/mem_wdata SHALL be 0 outside ARB_RD/ARB_WR.
REQ-028 rdata SHALL update only in ARB_RD; writes leave rdata unchanged.
REQ-029 Under continuous dual requests, grants SHALL strictly alternate 0,1,0,1.

Reset
REQ-030 rst_ low SHALL immediately force ARB_IDLE, ack0=ack1=0, mem_rd=mem_wr=0, busy=0, rdata=0, last_owner=1.
REQ-031 Reset during ARB_WR SHALL drop mem_wr before the next posedge; no memory write occurs.
REQ-032 After reset release, first tie SHALL be granted to requester 0.

Structure
REQ-033 Package mem_arb_pkg SHALL hold arb_state_e (enum logic [1:0]) and default AW/DW constants.
REQ-034 State register SHALL be a single always_ff; outputs from one always_comb decoded by state with unique case.
REQ-035 Sub-module rr_pick2_m (combinational 2-way round-robin picker: req[1:0], last -> grant, owner) SHALL be used.

Verification
REQ-036 Reset then req0 read addr 5'h0A, mem holds 8'h3C -> mem_rd one cycle, ack0 two cycles after sample, rdata=8'h3C.
REQ-037 req1 write addr 5'h1F data 8'hA5 -> mem_wr one cycle, ack1 strobe, subsequent req0 read 5'h1F returns 8'hA5.
REQ-038 req0 and req1 high same cycle, held 4 transfers -> grant order 0,1,0,1; acks never overlap.
REQ-039 rst_ pulsed low during ARB_WR to addr 5'h03 data 8'hFF -> mem_wr falls at once, mem[3] unchanged, state ARB_IDLE.
REQ-040 req0 dropped the cycle after grant -> ack0 still strobes; no second transfer issued.
